// File: rtl/cp0_wr_sched.sv
// cp0_wr_sched: shares the single CP0 write port between exception entry, ERET, MTC0 and Count.
// Build option CP0_TIMER_EN enables the Count tick, skipped-tick tracking and timer_int_o.
module cp0_wr_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        mtc0_req_i,
    input  logic [4:0]  mtc0_addr_i,
    input  logic [31:0] mtc0_data_i,
    output logic        mtc0_ack_o,
    input  logic        exc_req_i,
    input  logic [4:0]  exc_code_i,
    input  logic [31:0] exc_pc_i,
    output logic        exc_busy_o,
    output logic        exc_done_o,
    input  logic        eret_req_i,
    output logic        eret_ack_o,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] count_i,
    input  logic [31:0] compare_i,
    output logic        we_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o,
    output logic        timer_int_o
);

    localparam logic [4:0] AddrCount   = 5'd1;
    localparam logic [4:0] AddrCompare = 5'd2;
    localparam logic [4:0] AddrStatus  = 5'd3;
    localparam logic [4:0] AddrCause   = 5'd4;
    localparam logic [4:0] AddrEpc     = 5'd5;

    typedef enum logic [1:0] {StIdle, StExcEpc, StExcCause, StExcStatus} state_e;

    state_e      state_q;
    logic [4:0]  code_q;
    logic [31:0] pc_q;
    logic        we_q;
    logic [4:0]  waddr_q;
    logic [31:0] wdata_q;
    logic        mtc0_ack_q;
    logic        eret_ack_q;
    logic        exc_done_q;
    logic        exc_busy_q;
    logic        timer_q;

    logic is_idle;
    logic take_exc;
    logic take_eret;
    logic take_mtc0;
    logic port_free;

    always_comb begin
        is_idle   = (state_q == StIdle);
        take_exc  = is_idle & exc_req_i;
        // A request still high in its own ack cycle is the one just served.
        take_eret = is_idle & ~exc_req_i & eret_req_i & ~eret_ack_q;
        take_mtc0 = is_idle & ~exc_req_i & ~take_eret & mtc0_req_i & ~mtc0_ack_q;
        port_free = is_idle & ~exc_req_i & ~take_eret & ~take_mtc0;
    end

`ifdef CP0_TIMER_EN
    logic [2:0]  pending_q;
    logic [31:0] pend_inc;
    logic [31:0] count_next;
    logic [31:0] cmp_diff;
    logic        timer_hit;

    always_comb begin
        pend_inc   = {29'd0, pending_q} + 32'd1;
        count_next = count_i + pend_inc;
        cmp_diff   = compare_i - count_i;
        // Skipped values always fire; the value actually written needs a non-zero Compare.
        timer_hit  = (cmp_diff != 32'd0) &&
                     ((cmp_diff < pend_inc) || ((cmp_diff == pend_inc) && (compare_i != 32'd0)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 3'd0;
        end else if (port_free || (take_mtc0 && (mtc0_addr_i == AddrCount))) begin
            pending_q <= 3'd0;
        end else if (pending_q != 3'd7) begin
            pending_q <= pending_q + 3'd1;
        end
    end
`else
    logic unused_timer;
    assign unused_timer = ^{count_i, compare_i, port_free};
`endif

    logic unused_cause;
    assign unused_cause = ^cause_i[6:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            code_q     <= 5'd0;
            pc_q       <= 32'd0;
            we_q       <= 1'b0;
            waddr_q    <= 5'd0;
            wdata_q    <= 32'd0;
            mtc0_ack_q <= 1'b0;
            eret_ack_q <= 1'b0;
            exc_done_q <= 1'b0;
            exc_busy_q <= 1'b0;
            timer_q    <= 1'b0;
        end else begin
            we_q       <= 1'b0;
            waddr_q    <= 5'd0;
            wdata_q    <= 32'd0;
            mtc0_ack_q <= 1'b0;
            eret_ack_q <= 1'b0;
            exc_done_q <= 1'b0;
            exc_busy_q <= take_exc | ~is_idle;
            unique case (state_q)
                StIdle: begin
                    if (take_exc) begin
                        code_q  <= exc_code_i;
                        pc_q    <= exc_pc_i;
                        // EPC must not be overwritten while EXL is already set.
                        state_q <= status_i[1] ? StExcCause : StExcEpc;
                    end else if (take_eret) begin
                        we_q       <= 1'b1;
                        waddr_q    <= AddrStatus;
                        wdata_q    <= status_i & ~32'h2;
                        eret_ack_q <= 1'b1;
                    end else if (take_mtc0) begin
                        we_q       <= 1'b1;
                        waddr_q    <= mtc0_addr_i;
                        wdata_q    <= mtc0_data_i;
                        mtc0_ack_q <= 1'b1;
                        if (mtc0_addr_i == AddrCompare) begin
                            timer_q <= 1'b0;
                        end
                    end
`ifdef CP0_TIMER_EN
                    else begin
                        we_q    <= 1'b1;
                        waddr_q <= AddrCount;
                        wdata_q <= count_next;
                        if (timer_hit) begin
                            timer_q <= 1'b1;
                        end
                    end
`endif
                end
                StExcEpc: begin
                    we_q    <= 1'b1;
                    waddr_q <= AddrEpc;
                    wdata_q <= pc_q;
                    state_q <= StExcCause;
                end
                StExcCause: begin
                    we_q    <= 1'b1;
                    waddr_q <= AddrCause;
                    wdata_q <= {cause_i[31:7], code_q, cause_i[1:0]};
                    state_q <= StExcStatus;
                end
                StExcStatus: begin
                    we_q       <= 1'b1;
                    waddr_q    <= AddrStatus;
                    wdata_q    <= status_i | 32'h2;
                    exc_done_q <= 1'b1;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign we_o       = we_q;
    assign waddr_o    = waddr_q;
    assign wdata_o    = wdata_q;
    assign mtc0_ack_o = mtc0_ack_q;
    assign eret_ack_o = eret_ack_q;
    assign exc_done_o = exc_done_q;
    assign exc_busy_o = exc_busy_q;
`ifdef CP0_TIMER_EN
    assign timer_int_o = timer_q;
`else
    assign timer_int_o = 1'b0;
`endif

endmodule

// File: tb/tb_cp0_wr_sched.sv
// Bench for cp0_wr_sched: directed scenarios then random traffic against a queue-based model.
// Honours CP0_TIMER_EN the same way the design does.
module tb_cp0_wr_sched;

`ifdef CP0_TIMER_EN
    localparam bit TimerEn = 1'b1;
`else
    localparam bit TimerEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mtc0_req_i;
    logic [4:0]  mtc0_addr_i;
    logic [31:0] mtc0_data_i;
    logic        mtc0_ack_o;
    logic        exc_req_i;
    logic [4:0]  exc_code_i;
    logic [31:0] exc_pc_i;
    logic        exc_busy_o;
    logic        exc_done_o;
    logic        eret_req_i;
    logic        eret_ack_o;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] count_i;
    logic [31:0] compare_i;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic        timer_int_o;

    always #5 clk = ~clk;

    cp0_wr_sched dut (
        .clk         (clk),
        .rst         (rst),
        .mtc0_req_i  (mtc0_req_i),
        .mtc0_addr_i (mtc0_addr_i),
        .mtc0_data_i (mtc0_data_i),
        .mtc0_ack_o  (mtc0_ack_o),
        .exc_req_i   (exc_req_i),
        .exc_code_i  (exc_code_i),
        .exc_pc_i    (exc_pc_i),
        .exc_busy_o  (exc_busy_o),
        .exc_done_o  (exc_done_o),
        .eret_req_i  (eret_req_i),
        .eret_ack_o  (eret_ack_o),
        .status_i    (status_i),
        .cause_i     (cause_i),
        .count_i     (count_i),
        .compare_i   (compare_i),
        .we_o        (we_o),
        .waddr_o     (waddr_o),
        .wdata_o     (wdata_o),
        .timer_int_o (timer_int_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: exception entry is a list of register writes still owed.
    int unsigned exc_q[$];
    logic [4:0]  m_code = 5'd0;
    logic [31:0] m_pc   = 32'd0;
    int          m_pend = 0;
    bit          m_timer = 1'b0;

    bit          e_we = 1'b0;
    logic [4:0]  e_waddr = 5'd0;
    logic [31:0] e_wdata = 32'd0;
    bit          e_mack = 1'b0;
    bit          e_eack = 1'b0;
    bit          e_done = 1'b0;
    bit          e_busy = 1'b0;
    bit          e_timer = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_decide();
        bit          prev_m;
        bit          prev_e;
        bit          ticked;
        int unsigned k;
        prev_m = e_mack;
        prev_e = e_eack;
        ticked = 1'b0;
        e_we = 1'b0; e_waddr = 5'd0; e_wdata = 32'd0;
        e_mack = 1'b0; e_eack = 1'b0; e_done = 1'b0; e_busy = 1'b0;
        if (rst) begin
            exc_q.delete();
            m_pend  = 0;
            m_timer = 1'b0;
            e_timer = 1'b0;
            return;
        end
        if (exc_q.size() != 0) begin
            k = exc_q.pop_front();
            e_we    = 1'b1;
            e_waddr = 5'(k);
            e_busy  = 1'b1;
            if (k == 5) begin
                e_wdata = m_pc;
            end else if (k == 4) begin
                e_wdata = (cause_i & ~32'h7C) | ({27'd0, m_code} << 2);
            end else begin
                e_wdata = status_i | 32'h2;
                e_done  = 1'b1;
            end
        end else if (exc_req_i) begin
            m_code = exc_code_i;
            m_pc   = exc_pc_i;
            e_busy = 1'b1;
            if (!status_i[1]) exc_q.push_back(5);
            exc_q.push_back(4);
            exc_q.push_back(3);
        end else if (eret_req_i && !prev_e) begin
            e_we = 1'b1; e_waddr = 5'd3; e_wdata = status_i & 32'hFFFF_FFFD; e_eack = 1'b1;
        end else if (mtc0_req_i && !prev_m) begin
            e_we = 1'b1; e_waddr = mtc0_addr_i; e_wdata = mtc0_data_i; e_mack = 1'b1;
            if (mtc0_addr_i == 5'd2) m_timer = 1'b0;
        end else if (TimerEn) begin
            ticked  = 1'b1;
            e_we    = 1'b1;
            e_waddr = 5'd1;
            e_wdata = count_i + 32'(m_pend) + 32'd1;
            // Walk every value Count passed through since its last write.
            for (int s = 1; s <= m_pend + 1; s++) begin
                if ((count_i + 32'(s)) == compare_i && (s <= m_pend || compare_i != 32'd0))
                    m_timer = 1'b1;
            end
        end
        if (ticked || (e_mack && mtc0_addr_i == 5'd1)) m_pend = 0;
        else if (m_pend < 7) m_pend++;
        e_timer = TimerEn && m_timer;
    endtask

    task automatic compare_outputs();
        check_eq("we", 32'(we_o), 32'(e_we));
        if (e_we) begin
            check_eq("waddr", 32'(waddr_o), 32'(e_waddr));
            check_eq("wdata", wdata_o, e_wdata);
        end
        check_eq("mtc0_ack", 32'(mtc0_ack_o), 32'(e_mack));
        check_eq("eret_ack", 32'(eret_ack_o), 32'(e_eack));
        check_eq("exc_done", 32'(exc_done_o), 32'(e_done));
        check_eq("exc_busy", 32'(exc_busy_o), 32'(e_busy));
        check_eq("timer_int", 32'(timer_int_o), 32'(e_timer));
    endtask

    task automatic run_cycle();
        model_decide();
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    bit m_drop = 1'b0;
    bit e_drop = 1'b0;

    initial begin
        rst = 1'b1;
        mtc0_req_i = 1'b0; mtc0_addr_i = 5'd0; mtc0_data_i = 32'd0;
        exc_req_i = 1'b0; exc_code_i = 5'd0; exc_pc_i = 32'd0;
        eret_req_i = 1'b0;
        status_i = 32'd0; cause_i = 32'd0; count_i = 32'd0; compare_i = 32'd0;

        run_cycle();
        run_cycle();
        rst = 1'b0;

        // Idle: Count written every cycle.
        count_i = 32'h100;
        run_cycle();
        count_i = 32'h101;
        run_cycle();
        count_i = 32'h102;
        run_cycle();

        // Exception with EXL clear, then with EXL set.
        exc_req_i = 1'b1; exc_code_i = 5'h0C; exc_pc_i = 32'h100; cause_i = 32'hFFFF_FF83;
        run_cycle();
        exc_req_i = 1'b0;
        repeat (5) run_cycle();
        status_i = 32'h2;
        exc_req_i = 1'b1; exc_code_i = 5'h0C; exc_pc_i = 32'h200;
        run_cycle();
        exc_req_i = 1'b0;
        repeat (4) run_cycle();
        status_i = 32'h1;

        // ERET and MTC0 to Compare together.
        mtc0_req_i = 1'b1; mtc0_addr_i = 5'd2; mtc0_data_i = 32'h10; eret_req_i = 1'b1;
        count_i = 32'h500;
        run_cycle();
        run_cycle();
        eret_req_i = 1'b0;
        run_cycle();
        mtc0_req_i = 1'b0;
        run_cycle();

        // Timer fires on the written value, cleared by MTC0 to Compare.
        count_i = 32'h0F; compare_i = 32'h10;
        run_cycle();
        count_i = 32'h40;
        run_cycle();
        mtc0_req_i = 1'b1; mtc0_addr_i = 5'd2; mtc0_data_i = 32'h77;
        run_cycle();
        run_cycle();
        mtc0_req_i = 1'b0;
        run_cycle();

        // Count wrap.
        compare_i = 32'd0; count_i = 32'hFFFF_FFFF;
        run_cycle();
        run_cycle();

        // Reset while the Cause write is being decided.
        status_i = 32'h2; exc_req_i = 1'b1; exc_code_i = 5'h04;
        run_cycle();
        exc_req_i = 1'b0; rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        repeat (3) run_cycle();

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            exc_req_i  = ($urandom_range(0, 9) == 0);
            exc_code_i = 5'($urandom);
            exc_pc_i   = $urandom;
            if (mtc0_req_i) begin
                if (m_drop) begin
                    mtc0_req_i = 1'b0;
                    m_drop = 1'b0;
                end else if (e_mack) begin
                    m_drop = 1'b1;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                mtc0_req_i  = 1'b1;
                mtc0_addr_i = 5'($urandom_range(0, 7));
                mtc0_data_i = $urandom;
            end
            if (eret_req_i) begin
                if (e_drop) begin
                    eret_req_i = 1'b0;
                    e_drop = 1'b0;
                end else if (e_eack) begin
                    e_drop = 1'b1;
                end
            end else if ($urandom_range(0, 5) == 0) begin
                eret_req_i = 1'b1;
            end
            status_i = {$urandom_range(0, 1) == 0 ? 30'd0 : 30'($urandom),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
            cause_i  = $urandom;
            count_i  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 5))
                                                   : $urandom;
            compare_i = ($urandom_range(0, 3) == 0) ? 32'd0
                                                    : count_i + 32'($urandom_range(0, 9));
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_wr_sched.md
# cp0_wr_sched

Write-port scheduler for the CP0 register block. The CP0 register block has a single write port (write enable, 5-bit address, 32-bit data). This block shares that port between four sources:
- pipeline MTC0 writes,
- the multi-cycle exception-entry sequence,
- ERET,
- the free-running Count tick.

It also generates the timer interrupt. It sits between the MEM/WB stage and the CP0 register block.

## Interface
- CP0 address map (fixed): Count=1, Compare=2, Status=3, Cause=4, EPC=5. Status bit 1 = EXL.
- No parameters.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mtc0_req_i  in  1  MTC0 write request; held until ack
- mtc0_addr_i  in  5  MTC0 target register
- mtc0_data_i  in  32  MTC0 data
- mtc0_ack_o  out  1  pulse: MTC0 write driven this cycle
- exc_req_i  in  1  single-cycle exception pulse
- exc_code_i  in  5  ExcCode
- exc_pc_i  in  32  faulting PC
- exc_busy_o  out  1  exception sequence in progress
- exc_done_o  out  1  pulse on final exception write
- eret_req_i  in  1  ERET request; held until ack
- eret_ack_o  out  1  pulse: Status EXL clear driven this cycle
- status_i, cause_i, count_i, compare_i  in  32 each  current CP0 register values
- we_o  out  1  CP0 write enable
- waddr_o  out  5  CP0 write address
- wdata_o  out  32  CP0 write data
- timer_int_o  out  1  timer interrupt, level

## Operation
- States:
  - IDLE
  - EXC_EPC
  - EXC_CAUSE
  - EXC_STATUS
- Exception entry:
  - IDLE + exc_req_i: latch exc_code_i and exc_pc_i.
  - If status_i[1]=0: go to EXC_EPC. If status_i[1]=1: go to EXC_CAUSE (EPC is not overwritten while EXL is set).
- Exception write sequence:
  - EXC_EPC: write addr 5 = latched PC.
  - EXC_CAUSE: write addr 4 = {cause_i[31:7], code, cause_i[1:0]}.
  - EXC_STATUS: write addr 3 = status_i | 32'h2; assert exc_done_o; return to IDLE.
- exc_busy_o=1 in the latch cycle and in every non-IDLE state.
- exc_req_i while busy is ignored.
- Port priority in IDLE: exc_req_i > eret_req_i > mtc0_req_i > Count tick. The exc_req_i cycle itself performs no write.
- ERET (in IDLE, no exc_req_i): write addr 3 = status_i & ~32'h2; assert eret_ack_o.
- MTC0: write mtc0_addr_i/mtc0_data_i; assert mtc0_ack_o.
- Count tick:
  - A 3-bit pending counter increments every cycle the port is used by another source (saturates at 7).
  - In any cycle the port is otherwise free: write addr 1 = count_i + pending + 1 (32-bit wrap); clear pending.
  - An MTC0 to Count clears pending.
- Timer:
  - timer_int_o sets when compare_i != 0 and the Count value written this cycle equals compare_i.
  - It also sets when a skipped (pending) value would have equaled compare_i: compare_i - count_i in 1..pending+1, 32-bit modulo.
  - timer_int_o clears on an MTC0 write to addr 2.
  - If clear and set occur in the same cycle, clear wins.

## Timing
- All outputs are registered.
- Reset values:
  - we_o=0, waddr_o=0, wdata_o=0
  - all acks/done=0, exc_busy_o=0, timer_int_o=0
  - pending=0, state=IDLE
- Write cycle: a write decided in cycle N appears on we_o/waddr_o/wdata_o in cycle N+1; the matching ack/done pulse appears in the same cycle N+1.
- Exception latency: exc_req_i in cycle N produces EPC in N+2, Cause in N+3, Status in N+4 (exc_done_o). With EXL set, Cause is in N+2 and Status in N+3.
- Requesters must drop req the cycle after the ack; a req still high after that is treated as a new request.
- Reset mid-sequence: return to IDLE; no partial writes are completed.

## Configuration
- CP0_TIMER_EN defined: Count tick, pending counter and timer_int_o behave as specified.
- CP0_TIMER_EN undefined:
  - No Count writes are generated; pending logic is removed.
  - timer_int_o is tied 0.
  - MTC0 to Count/Compare still passes through.

## Test plan
- Reset, then idle with count_i tracking writes -> addr 1 written every cycle with count_i+1; all other outputs 0.
- exc_req_i, code=5'h0C, pc=32'h0000_0100, status_i=0 -> EPC=32'h100, Cause[6:2]=0x0C, Status=32'h2 on three consecutive cycles; exc_done_o on the third.
- Same with status_i=32'h2 -> no EPC write; Cause, then Status=32'h2; done one cycle earlier.
- mtc0_req_i to addr 2 with data 32'h10 concurrent with eret_req_i -> ERET acked first, MTC0 next cycle; Count resumes with pending+1 = 3 added.
- count_i=32'h0F, compare_i=32'h10, port free -> timer_int_o=1; then MTC0 to Compare -> timer_int_o=0 in the ack cycle.
- count_i=32'hFFFF_FFFF, pending=0 -> wdata_o=0 (wrap). rst asserted in EXC_CAUSE -> no Status write; IDLE next cycle.
